unidade_busca: RTL and testbench

Instruction-fetch stage of the single-issue MIPS pipeline. Holds the program counter and drives `counter` into `memoria_instrucoes`, which returns the addressed word on `instrucao_entrada` combinationally in the same cycle. The block selects the next PC (sequential, branch, jump or register jump) and registers the fetched word and its PC+4 into the IF/ID register consumed by decode. It supports stall, redirect flush and misaligned-target detection.

---
 rtl/unidade_busca_if.sv | 31 +++
 rtl/unidade_busca.sv | 94 +++++++++
 tb/tb_unidade_busca.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/unidade_busca_if.sv
// Fetch-stage bus: PC to instruction memory, redirect/stall controls from
// decode, and the IF/ID register contents handed to decode.
interface unidade_busca_if;
    logic [31:0] counter;
    logic [31:0] instrucao_entrada;
    logic        stall;
    logic        desvio_tomado;
    logic [15:0] desvio_offset;
    logic        salto;
    logic [25:0] salto_alvo;
    logic        salto_reg;
    logic [31:0] reg_alvo;
    logic [31:0] instrucao_saida;
    logic [31:0] pc_mais4_saida;
    logic        valido_saida;
    logic        erro_alinhamento;

    // fetch unit side
    modport master (
        output counter, instrucao_saida, pc_mais4_saida, valido_saida, erro_alinhamento,
        input  instrucao_entrada, stall, desvio_tomado, desvio_offset,
               salto, salto_alvo, salto_reg, reg_alvo
    );

    // memory / decode side
    modport slave (
        input  counter, instrucao_saida, pc_mais4_saida, valido_saida, erro_alinhamento,
        output instrucao_entrada, stall, desvio_tomado, desvio_offset,
               salto, salto_alvo, salto_reg, reg_alvo
    );
endinterface

// File: rtl/unidade_busca.sv
// Instruction fetch stage: PC register, next-PC selection (sequential,
// branch, jump, register jump) and the IF/ID pipeline register.
module unidade_busca #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input logic             clock,
    input logic             reset_n,
    unidade_busca_if.master bus
);

    typedef enum logic [1:0] {INICIO, BUSCA, ESPERA} estado_t;

    estado_t     estado, prox_estado;
    logic        redir;
    logic [31:0] alvo;
    logic [31:0] pc_seq;
    logic [31:0] pc_prox;
    logic [31:0] instr_prox;
    logic [31:0] pc4_prox;
    logic        valido_prox;
    logic        erro_prox;

    assign redir  = bus.salto_reg | bus.salto | bus.desvio_tomado;
    assign pc_seq = bus.counter + 32'd4;

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= INICIO;
        else          estado <= prox_estado;
    end

    // next state: boot cycle is always one cycle; ESPERA only on a stall without redirect
    always_comb begin
        prox_estado = BUSCA;
        case (estado)
            INICIO:  prox_estado = BUSCA;
            default: prox_estado = (bus.stall && !redir) ? ESPERA : BUSCA;
        endcase
    end

    // redirect target; register jump wins over jump, jump over branch
    always_comb begin
        if (bus.salto_reg)
            alvo = {bus.reg_alvo[31:2], 2'b00};
        else if (bus.salto)
            alvo = {bus.pc_mais4_saida[31:28], bus.salto_alvo, 2'b00};
        else
            alvo = bus.pc_mais4_saida + {{14{bus.desvio_offset[15]}}, bus.desvio_offset, 2'b00};
    end

    // output logic: next PC, IF/ID contents and sticky alignment error
    always_comb begin
        pc_prox     = bus.counter;
        instr_prox  = bus.instrucao_saida;
        pc4_prox    = bus.pc_mais4_saida;
        valido_prox = bus.valido_saida;
        erro_prox   = bus.erro_alinhamento;
        if (estado != INICIO) begin
            if (redir) begin
                // flush: the instruction fetched this cycle is on the wrong path
                pc_prox     = alvo;
                instr_prox  = NOP;
                pc4_prox    = 32'd0;
                valido_prox = 1'b0;
                if (bus.salto_reg && (bus.reg_alvo[1:0] != 2'b00))
                    erro_prox = 1'b1;
            end else if (!bus.stall) begin
                pc_prox     = pc_seq;
                instr_prox  = bus.instrucao_entrada;
                pc4_prox    = pc_seq;
                valido_prox = 1'b1;
            end
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.counter          <= PC_RESET;
            bus.instrucao_saida  <= NOP;
            bus.pc_mais4_saida   <= 32'd0;
            bus.valido_saida     <= 1'b0;
            bus.erro_alinhamento <= 1'b0;
        end else begin
            bus.counter          <= pc_prox;
            bus.instrucao_saida  <= instr_prox;
            bus.pc_mais4_saida   <= pc4_prox;
            bus.valido_saida     <= valido_prox;
            bus.erro_alinhamento <= erro_prox;
        end
    end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed scenarios with literal expectations plus
// randomized redirect/stall/reset traffic compared against a behavioural model.
module tb_unidade_busca;

    localparam logic [31:0] PCR1 = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP1 = 32'hDEAD_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0, desvio_tomado = 1'b0, salto = 1'b0, salto_reg = 1'b0;
    logic [15:0] desvio_offset = '0;
    logic [25:0] salto_alvo = '0;
    logic [31:0] reg_alvo = '0;
    int          n_chk = 0, n_pass = 0;
    bit          chk_en = 1'b0;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h1111_1111;
            32'd4:   return 32'h2222_2222;
            32'd8:   return 32'h3333_3333;
            default: return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
        endcase
    endfunction

    unidade_busca_if bi0 ();
    unidade_busca_if bi1 ();

    assign bi0.instrucao_entrada = mem_word(bi0.counter);
    assign bi0.stall = stall;           assign bi0.desvio_tomado = desvio_tomado;
    assign bi0.desvio_offset = desvio_offset;
    assign bi0.salto = salto;           assign bi0.salto_alvo = salto_alvo;
    assign bi0.salto_reg = salto_reg;   assign bi0.reg_alvo = reg_alvo;
    assign bi1.instrucao_entrada = mem_word(bi1.counter);
    assign bi1.stall = stall;           assign bi1.desvio_tomado = desvio_tomado;
    assign bi1.desvio_offset = desvio_offset;
    assign bi1.salto = salto;           assign bi1.salto_alvo = salto_alvo;
    assign bi1.salto_reg = salto_reg;   assign bi1.reg_alvo = reg_alvo;

    unidade_busca #(.PC_RESET(32'h0), .NOP(32'h0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(bi0));
    unidade_busca #(.PC_RESET(PCR1),  .NOP(NOP1))  dut1 (.clock(clock), .reset_n(reset_n), .bus(bi1));

    // behavioural model: one record per DUT
    typedef struct {
        logic [31:0] pc, instr, pc4;
        logic        valid, err, boot;
    } model_t;

    model_t m0, m1;

    function automatic model_t rst_model(input logic [31:0] pcr, input logic [31:0] nop);
        model_t r;
        r.pc = pcr; r.instr = nop; r.pc4 = 0; r.valid = 0; r.err = 0; r.boot = 1;
        return r;
    endfunction

    function automatic model_t step(input model_t m, input logic [31:0] nop);
        model_t n = m;
        if (m.boot) begin
            n.boot = 0;
            return n;
        end
        if (salto_reg || salto || desvio_tomado) begin
            if (salto_reg) begin
                n.pc = (reg_alvo / 4) * 4;
                if (reg_alvo % 4 != 0) n.err = 1;
            end else if (salto) begin
                n.pc = (m.pc4 & 32'hF000_0000) + 32'(salto_alvo) * 4;
            end else begin
                n.pc = m.pc4 + 32'($signed(desvio_offset)) * 4;
            end
            n.instr = nop; n.pc4 = 0; n.valid = 0;
        end else if (!stall) begin
            n.instr = mem_word(m.pc); n.pc4 = m.pc + 4; n.valid = 1; n.pc = m.pc + 4;
        end
        return n;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m0 <= rst_model(32'h0, 32'h0);
            m1 <= rst_model(PCR1, NOP1);
        end else begin
            m0 <= step(m0, 32'h0);
            m1 <= step(m1, NOP1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp(input string tag, input model_t m, input logic [31:0] c, input logic [31:0] i,
                       input logic [31:0] p, input logic v, input logic e);
        chk({tag, ".counter"}, c, m.pc);
        chk({tag, ".instr"}, i, m.instr);
        chk({tag, ".pc4"}, p, m.pc4);
        chk({tag, ".valid"}, 32'(v), 32'(m.valid));
        chk({tag, ".erro"}, 32'(e), 32'(m.err));
    endtask

    // per-cycle model comparison
    always @(negedge clock) begin
        if (chk_en) begin
            cmp("m0", m0, bi0.counter, bi0.instrucao_saida, bi0.pc_mais4_saida, bi0.valido_saida, bi0.erro_alinhamento);
            cmp("m1", m1, bi1.counter, bi1.instrucao_saida, bi1.pc_mais4_saida, bi1.valido_saida, bi1.erro_alinhamento);
        end
    end

    task automatic nxt();
        @(negedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1 chk_en = 1'b1;
        chk("boot.valid", 32'(bi0.valido_saida), 0);
        chk("boot.counter", bi0.counter, 0);
        chk("boot1.counter", bi1.counter, PCR1);
        chk("boot1.instr", bi1.instrucao_saida, NOP1);
        nxt();
        chk("inicio.valid", 32'(bi0.valido_saida), 0);
        chk("inicio.counter", bi0.counter, 0);
        nxt();
        chk("f0.instr", bi0.instrucao_saida, 32'h1111_1111);
        chk("f0.pc4", bi0.pc_mais4_saida, 4);
        chk("w.counter1", bi1.counter, 32'hFFFF_FFFC);
        nxt();
        chk("f1.instr", bi0.instrucao_saida, 32'h2222_2222);
        chk("f1.pc4", bi0.pc_mais4_saida, 8);
        chk("f1.counter", bi0.counter, 8);
        chk("w.counter2", bi1.counter, 32'h0);
        chk("w.pc4", bi1.pc_mais4_saida, 32'h0);
        chk("w.valid", 32'(bi1.valido_saida), 1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nxt();
            chk("stall.counter", bi0.counter, 8);
            chk("stall.instr", bi0.instrucao_saida, 32'h2222_2222);
            chk("stall.pc4", bi0.pc_mais4_saida, 8);
        end
        stall = 1'b0;
        nxt();
        chk("f2.instr", bi0.instrucao_saida, 32'h3333_3333);
        chk("f2.pc4", bi0.pc_mais4_saida, 12);
        nxt();
        chk("br.pc4pre", bi0.pc_mais4_saida, 32'h10);
        desvio_tomado = 1'b1; desvio_offset = 16'hFFFC;
        nxt();
        desvio_tomado = 1'b0;
        chk("br.counter", bi0.counter, 0);
        chk("br.valid", 32'(bi0.valido_saida), 0);
        chk("br.instr", bi0.instrucao_saida, 0);
        nxt();
        chk("br.tgt.valid", 32'(bi0.valido_saida), 1);
        chk("br.tgt.instr", bi0.instrucao_saida, 32'h1111_1111);
        salto_reg = 1'b1; reg_alvo = 32'h0000_0102; salto = 1'b1; salto_alvo = 26'h3; stall = 1'b1;
        nxt();
        chk("jr.counter", bi0.counter, 32'h100);
        chk("jr.erro", 32'(bi0.erro_alinhamento), 1);
        chk("jr.valid", 32'(bi0.valido_saida), 0);
        salto = 1'b0; stall = 1'b0; reg_alvo = 32'h0000_0200;
        nxt();
        chk("jr2.counter", bi0.counter, 32'h200);
        chk("jr2.erro", 32'(bi0.erro_alinhamento), 1);
        salto_reg = 1'b0; stall = 1'b1;
        nxt();
        #1 reset_n = 1'b0;
        #1;
        chk("arst.counter", bi0.counter, 0);
        chk("arst.erro", 32'(bi0.erro_alinhamento), 0);
        chk("arst.valid", 32'(bi0.valido_saida), 0);
        chk("arst.pc4", bi0.pc_mais4_saida, 0);
        chk("arst.counter1", bi1.counter, PCR1);
        nxt();
        reset_n = 1'b1;
        // random traffic, with occasional mid-cycle resets
        for (int c = 0; c < 600; c++) begin
            nxt();
            if (!reset_n) reset_n = 1'b1;
            stall         = ($urandom_range(0, 3) == 0);
            desvio_tomado = ($urandom_range(0, 7) == 0);
            salto         = ($urandom_range(0, 9) == 0);
            salto_reg     = ($urandom_range(0, 9) == 0);
            desvio_offset = 16'($urandom);
            salto_alvo    = 26'($urandom);
            reg_alvo      = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                #1 reset_n = 1'b0;
            end
        end
        nxt();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
